// File: rtl/image_threshold_stream.sv
// Streaming per-pixel threshold stage: registered compute, small output FIFO,
// per-frame configuration latched on the first pixel of each frame.
module image_threshold_stream #(
   parameter int                    DATA_WIDTH   = 8,
   parameter int                    DEPTH        = 4,
   parameter int                    FRAME_PIXELS = 262144,
   parameter logic [DATA_WIDTH-1:0] HI_VALUE     = '1
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [DATA_WIDTH-1:0] In1_DATA,
   input  logic                  In1_SEND,
   input  logic [15:0]           In1_COUNT,
   output logic                  In1_ACK,
   output logic [DATA_WIDTH-1:0] Out1_DATA,
   output logic                  Out1_SEND,
   input  logic                  Out1_RDY,
   input  logic                  Out1_ACK,
   output logic [15:0]           Out1_COUNT,
   input  logic [DATA_WIDTH-1:0] cfg_threshold,
   input  logic [1:0]            cfg_mode,
   output logic                  frame_done,
   output logic [31:0]           pixel_index
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [31:0] FRAME_LAST = 32'(FRAME_PIXELS - 1);

   logic [DATA_WIDTH-1:0] fifo_mem [DEPTH];
   logic [AW-1:0]         rd_ptr, wr_ptr;
   logic [CW-1:0]         fifo_count, occupancy;
   logic                  stage_valid;
   logic [DATA_WIDTH-1:0] stage_data;
   logic [DATA_WIDTH-1:0] act_thr, use_thr, result;
   logic [1:0]            act_mode, use_mode;
   logic [31:0]           in_cnt, out_cnt;
   logic                  accept, emit, fifo_wr, first_px, above;
   logic                  unused_inputs;

   assign unused_inputs = ^{In1_COUNT, Out1_ACK};

   // The stage register counts toward occupancy so a token is never accepted
   // without a guaranteed FIFO slot behind it.
   assign occupancy = fifo_count + CW'(stage_valid);
   assign accept    = In1_SEND & ~RESET & (occupancy < CW'(DEPTH));
   assign emit      = (fifo_count != '0) & Out1_RDY & ~RESET;
   assign fifo_wr   = stage_valid & ~RESET;
   assign first_px  = (in_cnt == '0);

   // The first pixel of a frame already uses the incoming configuration.
   assign use_thr = first_px ? cfg_threshold : act_thr;
   assign use_mode = first_px ? cfg_mode : act_mode;
   assign above   = In1_DATA > use_thr;

   always_comb begin
      result = '0;
      case (use_mode)
         2'd0:    result = above ? HI_VALUE : '0;
         2'd1:    result = above ? '0 : HI_VALUE;
         2'd2:    result = above ? In1_DATA : '0;
         default: result = above ? use_thr : In1_DATA;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         stage_valid <= 1'b0;
         stage_data  <= '0;
         act_thr     <= '0;
         act_mode    <= '0;
         in_cnt      <= '0;
         out_cnt     <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         fifo_count  <= '0;
      end else begin
         stage_valid <= accept;
         if (accept) begin
            stage_data <= result;
            in_cnt     <= (in_cnt == FRAME_LAST) ? '0 : in_cnt + 32'd1;
            if (first_px) begin
               act_thr  <= cfg_threshold;
               act_mode <= cfg_mode;
            end
         end
         if (emit) begin
            out_cnt <= (out_cnt == FRAME_LAST) ? '0 : out_cnt + 32'd1;
            rd_ptr  <= rd_ptr + AW'(1);
         end
         if (fifo_wr) wr_ptr <= wr_ptr + AW'(1);
         case ({fifo_wr, emit})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (fifo_wr) fifo_mem[wr_ptr] <= stage_data;
   end

   assign In1_ACK     = accept;
   assign Out1_SEND   = emit;
   assign Out1_DATA   = emit ? fifo_mem[rd_ptr] : '0;
   assign Out1_COUNT  = 16'h1;
   assign frame_done  = emit & (out_cnt == FRAME_LAST);
   assign pixel_index = in_cnt;

endmodule

// File: doc/image_threshold_stream.md
Name: image_threshold_stream

Overview:
Parametrised streaming threshold actor for the threshold micro-benchmark pipeline. It replaces the fixed 8-bit pass-through image stage with a registered compute stage and a small output FIFO. Each pixel is classified against a per-frame threshold in one of four modes. It sits between the image source actor and the sink, and uses the standard actor SEND/ACK/RDY/COUNT port handshake.

Parameters:
DATA_WIDTH, 8, pixel width in bits (minimum 2).
DEPTH, 4, output FIFO entries; power of 2, at least 2. A value of 4 or more is needed for one token per cycle.
FRAME_PIXELS, 262144, pixels per frame (512x512); at least 2.
HI_VALUE, all ones of DATA_WIDTH, foreground value for binary modes.

Ports:
CLK  in  1  clock; all state on rising edge.
RESET  in  1  synchronous, active-high reset.
In1_DATA  in  DATA_WIDTH  input pixel.
In1_SEND  in  1  input token available.
In1_COUNT  in  16  token count from upstream; ignored (tokens are always 1).
In1_ACK  out  1  input token consumed this cycle.
Out1_DATA  out  DATA_WIDTH  output pixel; valid when Out1_SEND is high.
Out1_SEND  out  1  output token emitted this cycle.
Out1_RDY  in  1  downstream can accept a token this cycle.
Out1_ACK  in  1  unused; tie-off only.
Out1_COUNT  out  16  constant 16'h1.
cfg_threshold  in  DATA_WIDTH  threshold T.
cfg_mode  in  2  0=binary, 1=inverted binary, 2=to-zero, 3=truncate.
frame_done  out  1  one-cycle pulse when the last pixel of a frame is emitted.
pixel_index  out  32  count of pixels accepted in the current frame.

Behaviour:
- Reset (sampled on CLK edge while RESET=1):
  - Clears FIFO, stage-valid, both frame counters, active threshold (0) and active mode (0).
  - In1_ACK=0, Out1_SEND=0, Out1_DATA=0, frame_done=0, pixel_index=0, Out1_COUNT=1.
  - Tokens in flight at reset are discarded, never emitted.
- Accept rule: In1_ACK = In1_SEND & ~RESET & (fifo_count + stage_valid < DEPTH). This is combinational, at most one token per cycle.
- Config latch:
  - On the ACK of the pixel where in_cnt==0, the active threshold and mode take cfg_threshold and cfg_mode. That pixel uses the new values.
  - Config changes mid-frame have no effect until the next frame start.
- Compute (unsigned compare, P=pixel, T=active threshold):
  - mode0: P>T ? HI_VALUE : 0.
  - mode1: P>T ? 0 : HI_VALUE.
  - mode2: P>T ? P : 0.
  - mode3: P>T ? T : P.
  - Result is registered in the stage register, with stage_valid=1 the cycle after ACK.
- FIFO:
  - Stage result is written the cycle after it is valid.
  - Read when Out1_SEND=1. Simultaneous read and write leaves the count unchanged.
  - Never overflows (guaranteed by the accept rule); never underflows.
- Output:
  - Out1_SEND = fifo non-empty & Out1_RDY.
  - Out1_DATA = FIFO head when Out1_SEND is high, else 0.
- Latency: a token ACKed in cycle N produces Out1_SEND no earlier than N+2, given Out1_RDY=1.
- Throughput: 1 token/cycle when DEPTH >= 4 and Out1_RDY is held high.
- Ordering: strict FIFO; no loss or duplication under any RDY pattern.
- Counters:
  - in_cnt increments on ACK and wraps to 0 after FRAME_PIXELS-1; pixel_index = in_cnt.
  - out_cnt increments on Out1_SEND; on the emit where out_cnt==FRAME_PIXELS-1, frame_done=1 for that cycle and out_cnt wraps to 0.
- Frame overlap: frame N+1 may be accepted while the tail of frame N is buffered. Each pixel keeps the config of its own frame.

Test Plan:
- Reset; mode0, T=0x7F; stream 00,7F,80,FF with RDY=1 -> Out1_DATA 00,00,FF,FF in order; first Out1_SEND exactly 2 cycles after first In1_ACK; Out1_COUNT=1 throughout.
- Mode3 T=0x40: 10,40,41,C0 -> 10,40,40,40. Mode2 T=0x40 on the same inputs -> 00,00,41,C0.
- DEPTH=4, RDY=0, In1_SEND held high -> exactly 4 In1_ACK pulses, then ACK stays 0. Raise RDY -> 4 tokens out in order on consecutive cycles, and ACK resumes.
- FRAME_PIXELS=16, mode0 T=0x80; cfg_mode set to 1 at pixel 5 -> frame 1 stays mode0; frame 2 is inverted from its first pixel. frame_done pulses exactly once, on the 16th and 32nd emits.
- Three tokens buffered, RDY=0, assert RESET for one cycle -> next cycle Out1_SEND=0, pixel_index=0. Raising RDY emits nothing until new input arrives.
- DATA_WIDTH=10, mode1, T=0x200: inputs 0x3FF, 0x200, 0x000 -> 0x000, 0x3FF, 0x3FF.
